// File: rtl/serial_capture_pkg.sv
// Shared types and helpers for the serial run-length capture block.
package serial_capture_pkg;

  localparam int CNT_W_DEFAULT = 8;

  typedef struct packed {
    logic                     level;
    logic [CNT_W_DEFAULT-1:0] length;
  } run_rec_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_run_capture_fifo.sv
// Small synchronous record FIFO; pointers carry an extra wrap bit so full and
// empty fall out of a pointer compare instead of an occupancy counter.
module run_fifo
  import serial_capture_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    // At full, a same-cycle pop frees the slot the push is about to reuse.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    head_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        mem_q[gi] <= '0;
      end else if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/serial_run_capture.sv
// Synchronizes a serial level, measures each constant-level run in clock
// cycles and queues {level, length} records behind a valid/ready port.
module serial_run_capture
  import serial_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             din,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic             rd_level,
  output logic [CNT_W-1:0] rd_length,
  output logic             overflow,
  output logic             level_q
);

  localparam int               REC_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] LEN_MAX = '1;

  logic             sync1_q;
  logic             sync2_q;
  logic             prev_q;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             overflow_q, overflow_d;

  logic             edge_det;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] head;
  logic [REC_W-1:0] wr_rec;

  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      run_len_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= din;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      run_len_q  <= run_len_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    edge_det  = (sync2_q != prev_q);
    rd_valid  = !fifo_empty;
    pop       = rd_valid && rd_ready;
    wr_rec    = {prev_q, run_len_q};
    run_len_d = run_len_q;
    // The new level has already held for one cycle when the edge is seen.
    if (edge_det) begin
      run_len_d = CNT_W'(1);
    end else if (run_len_q != LEN_MAX) begin
      run_len_d = run_len_q + 1'b1;
    end
    overflow_d = overflow_q | (edge_det & fifo_full & !pop);
  end

  run_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(REC_W)
  ) u_fifo (
    .clk_i  (clkin),
    .srst_i (reset),
    .push_i (edge_det),
    .pop_i  (pop),
    .wdata_i(wr_rec),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (head)
  );

  always_comb begin
    rd_level  = rd_valid ? head[CNT_W] : 1'b0;
    rd_length = rd_valid ? head[CNT_W-1:0] : '0;
    overflow  = overflow_q;
    level_q   = sync2_q;
  end

endmodule
